// File: rtl/bldc_commutator.sv
// bldc_commutator: six-step commutation controller for one brushless motor
// channel. Filters the Hall sensors, selects the high-side/low-side phase
// pair, inserts a dead gap on every commutation change and hands a duty value
// to the downstream PWM generators that only changes at period boundaries.
//
// Ports:
//   clock        system clock
//   reset_n      asynchronous active-low reset (synchronous deassert expected)
//   enable       motor run request (level)
//   direction    0 = forward, 1 = reverse
//   hall         raw Hall sensors {C,B,A}, asynchronous to clock
//   duty_cmd     requested duty
//   duty_load    one-cycle strobe, captures duty_cmd into the pending register
//   fault_clear  one-cycle strobe, leaves FAULT when the Hall code is valid
//   high_en      per-phase {C,B,A} high-side PWM gate enable
//   low_en       per-phase {C,B,A} low-side gate enable
//   duty_out     duty for the active high-side phase (0 outside RUN)
//   period_start one-cycle pulse when the period counter wraps to 0
//   fault        invalid Hall code latched
module bldc_commutator #(
    parameter int DUTY_CYCLE_WIDTH = 9,
    parameter int PERIOD           = 512,
    parameter int SWITCH_GAP       = 8,
    parameter int HALL_FILTER      = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        direction,
    input  logic [2:0]                  hall,
    input  logic [DUTY_CYCLE_WIDTH-1:0] duty_cmd,
    input  logic                        duty_load,
    input  logic                        fault_clear,
    output logic [2:0]                  high_en,
    output logic [2:0]                  low_en,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_out,
    output logic                        period_start,
    output logic                        fault
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int FW = $clog2(HALL_FILTER + 1);
    localparam int GW = $clog2(SWITCH_GAP + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(HALL_FILTER - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(SWITCH_GAP - 1);

    typedef enum logic [1:0] {S_DISABLED, S_RUN, S_SWITCH, S_FAULT} state_t;

    // ---------------- Hall synchronizer and stability filter ----------------
    logic [2:0]    sync1_reg, sync2_reg, cand_reg, accepted_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          acquired_reg;  // set once any code has been accepted

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg    <= 3'b000;
            sync2_reg    <= 3'b000;
            cand_reg     <= 3'b000;
            accepted_reg <= 3'b000;
            filt_cnt_reg <= '0;
            acquired_reg <= 1'b0;
        end else begin
            sync1_reg <= hall;
            sync2_reg <= sync1_reg;
            cand_reg  <= sync2_reg;  // previous synchronized sample
            if (sync2_reg == accepted_reg) begin
                filt_cnt_reg <= '0;
            end else if (sync2_reg != cand_reg) begin
                // New candidate: this cycle is the first stable one.
                filt_cnt_reg <= FW'(1);
            end else if (filt_cnt_reg >= FILT_LAST) begin
                accepted_reg <= sync2_reg;
                acquired_reg <= 1'b1;
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + FW'(1);
            end
        end
    end

    logic code_valid;
    assign code_valid = (accepted_reg != 3'b000) && (accepted_reg != 3'b111);

    // Forward table gives {high, low}; reverse swaps the two phases.
    function automatic logic [5:0] commutate(input logic [2:0] code, input logic rev);
        logic [2:0] hi_ph;
        logic [2:0] lo_ph;
        hi_ph = 3'b000;
        lo_ph = 3'b000;
        case (code)
            3'b001:  begin hi_ph = 3'b001; lo_ph = 3'b010; end
            3'b011:  begin hi_ph = 3'b001; lo_ph = 3'b100; end
            3'b010:  begin hi_ph = 3'b010; lo_ph = 3'b100; end
            3'b110:  begin hi_ph = 3'b010; lo_ph = 3'b001; end
            3'b100:  begin hi_ph = 3'b100; lo_ph = 3'b001; end
            3'b101:  begin hi_ph = 3'b100; lo_ph = 3'b010; end
            default: begin hi_ph = 3'b000; lo_ph = 3'b000; end
        endcase
        return rev ? {lo_ph, hi_ph} : {hi_ph, lo_ph};
    endfunction

    logic [5:0] step_pair;
    assign step_pair = commutate(accepted_reg, direction);

    // ---------------- Period counter and duty double-buffer -----------------
    logic [CW-1:0]               cnt_reg;
    logic [DUTY_CYCLE_WIDTH-1:0] pending_reg, applied_reg, applied_next;
    logic                        wrap;

    assign wrap         = (cnt_reg == CNT_LAST);
    assign applied_next = wrap ? pending_reg : applied_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg      <= '0;
            period_start <= 1'b0;
            pending_reg  <= '0;
            applied_reg  <= '0;
        end else begin
            cnt_reg      <= wrap ? '0 : cnt_reg + CW'(1);
            period_start <= wrap;
            // On a coinciding load the old pending value is the one applied.
            applied_reg  <= applied_next;
            if (duty_load) begin
                pending_reg <= duty_cmd;
            end
        end
    end

    // ---------------- Commutation state machine -----------------------------
    state_t        state_reg;
    logic [2:0]    run_code_reg;
    logic          run_dir_reg;
    logic [GW-1:0] gap_cnt_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_DISABLED;
            run_code_reg <= 3'b000;
            run_dir_reg  <= 1'b0;
            gap_cnt_reg  <= '0;
            high_en      <= 3'b000;
            low_en       <= 3'b000;
            duty_out     <= '0;
            fault        <= 1'b0;
        end else begin
            // Gates and duty default off; only RUN drives them.
            high_en  <= 3'b000;
            low_en   <= 3'b000;
            duty_out <= '0;
            case (state_reg)
                S_DISABLED: begin
                    fault <= 1'b0;
                    if (enable && code_valid) begin
                        state_reg         <= S_RUN;
                        run_code_reg      <= accepted_reg;
                        run_dir_reg       <= direction;
                        {high_en, low_en} <= step_pair;
                        duty_out          <= applied_next;
                    end else if (enable && acquired_reg) begin
                        // The 000 left by reset is "no code yet", not a fault.
                        state_reg <= S_FAULT;
                        fault     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!enable) begin
                        state_reg <= S_DISABLED;
                    end else if (!code_valid) begin
                        state_reg <= S_FAULT;
                        fault     <= 1'b1;
                    end else if (accepted_reg != run_code_reg || direction != run_dir_reg) begin
                        state_reg   <= S_SWITCH;
                        gap_cnt_reg <= '0;
                    end else begin
                        {high_en, low_en} <= step_pair;
                        duty_out          <= applied_next;
                    end
                end
                S_SWITCH: begin
                    if (!enable) begin
                        state_reg <= S_DISABLED;
                    end else if (!code_valid) begin
                        state_reg <= S_FAULT;
                        fault     <= 1'b1;
                    end else if (gap_cnt_reg == GAP_LAST) begin
                        // Exit uses the latest step, so changes seen during
                        // the gap are honoured without restarting it.
                        state_reg         <= S_RUN;
                        run_code_reg      <= accepted_reg;
                        run_dir_reg       <= direction;
                        {high_en, low_en} <= step_pair;
                        duty_out          <= applied_next;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GW'(1);
                    end
                end
                S_FAULT: begin
                    if (fault_clear && code_valid) begin
                        state_reg <= S_DISABLED;
                        fault     <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_DISABLED;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bldc_commutator.sv
// tb_bldc_commutator: scenario bench for bldc_commutator. Expected gate
// pairs come from a step-index model of the six-step sequence; expected
// timing comes from the filter, synchronizer and gap lengths.
module tb_bldc_commutator;

    localparam int DW         = 9;
    localparam int PERIOD     = 512;
    localparam int GAP        = 8;
    localparam int FILT       = 16;
    localparam int ACCEPT_LAT = 2 + FILT;  // raw Hall edge to accepted code

    localparam logic [2:0] FWD_SEQ [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          direction = 1'b0;
    logic [2:0]    hall = 3'b000;
    logic [DW-1:0] duty_cmd = '0;
    logic          duty_load = 1'b0;
    logic          fault_clear = 1'b0;
    logic [2:0]    high_en;
    logic [2:0]    low_en;
    logic [DW-1:0] duty_out;
    logic          period_start;
    logic          fault;

    bldc_commutator #(
        .DUTY_CYCLE_WIDTH(DW), .PERIOD(PERIOD), .SWITCH_GAP(GAP), .HALL_FILTER(FILT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .direction(direction),
        .hall(hall), .duty_cmd(duty_cmd), .duty_load(duty_load),
        .fault_clear(fault_clear), .high_en(high_en), .low_en(low_en),
        .duty_out(duty_out), .period_start(period_start), .fault(fault)
    );

    always #5 clock = ~clock;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [2:0]    cur_code = 3'b001;
    logic          cur_dir = 1'b0;
    logic [DW-1:0] cur_duty = '0;

    // Position of a code in the forward rotation, -1 when invalid.
    function automatic int code_index(input logic [2:0] code);
        for (int i = 0; i < 6; i++) if (FWD_SEQ[i] == code) return i;
        return -1;
    endfunction

    // Step i drives phase i/2 high and phase ((i+1)/2+1)%3 low; reverse swaps.
    function automatic logic [5:0] model_pair(input logic [2:0] code, input logic dir);
        int idx;
        logic [2:0] h;
        logic [2:0] l;
        idx = code_index(code);
        if (idx < 0) return 6'b000000;
        h = 3'b001 << (idx / 2);
        l = 3'b001 << (((idx + 1) / 2 + 1) % 3);
        return dir ? {l, h} : {h, l};
    endfunction

    function automatic logic [2:0] other_code(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] c;
        do c = FWD_SEQ[$urandom_range(0, 5)]; while (c == a || c == b);
        return c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        n_cmp++; if (high_en !== 3'b000) begin n_bad++; $display("FAIL reset_high got %b want 000", high_en); end
        n_cmp++; if (low_en !== 3'b000) begin n_bad++; $display("FAIL reset_low got %b want 000", low_en); end
        n_cmp++; if (duty_out !== '0) begin n_bad++; $display("FAIL reset_duty got %0d want 0", duty_out); end
        n_cmp++; if (period_start !== 1'b0) begin n_bad++; $display("FAIL reset_pstart got %b want 0", period_start); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got %b want 0", fault); end
        $display("reset: outputs sampled in reset");
    endtask

    task automatic test_startup();
        hall = 3'b001; cur_code = 3'b001; cur_dir = 1'b0; direction = 1'b0; enable = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 1; k <= ACCEPT_LAT; k++) begin
            tick();
            n_cmp++;
            if ({high_en, low_en} !== 6'b0) begin
                n_bad++; $display("FAIL startup_off cycle %0d got %b/%b want 000/000", k, high_en, low_en);
            end
        end
        tick();
        n_cmp++;
        if ({high_en, low_en} !== model_pair(cur_code, cur_dir) || duty_out !== cur_duty) begin
            n_bad++; $display("FAIL startup_run got %b/%b duty %0d want %b duty %0d",
                              high_en, low_en, duty_out, model_pair(cur_code, cur_dir), cur_duty);
        end
        $display("startup: hall=001 enable=1, pair expected after %0d cycles", ACCEPT_LAT + 1);
    endtask

    task automatic test_duty();
        int waited;
        logic [DW-1:0] d1, d2;
        waited = 0;
        while (period_start !== 1'b1 && waited < PERIOD + 2) begin tick(); waited++; end
        n_cmp++; if (period_start !== 1'b1) begin n_bad++; $display("FAIL duty_wait_pstart got %b want 1", period_start); end
        // Sample point is counter==0; load at counter==100.
        repeat (100) tick();
        do d1 = DW'($urandom_range(1, (1 << DW) - 1)); while (d1 == cur_duty);
        if (d1 == DW'(0)) d1 = DW'(200);
        duty_cmd = d1; duty_load = 1'b1;
        tick();
        duty_load = 1'b0;
        $display("duty: load %0d at counter 100", d1);
        for (int c = 101; c < PERIOD; c++) begin
            if (c != 101) tick();
            n_cmp++;
            if (duty_out !== cur_duty || period_start !== 1'b0) begin
                n_bad++; $display("FAIL duty_hold counter %0d got %0d ps %b want %0d ps 0", c, duty_out, period_start, cur_duty);
            end
        end
        tick();
        n_cmp++;
        if (duty_out !== d1 || period_start !== 1'b1) begin
            n_bad++; $display("FAIL duty_apply got %0d ps %b want %0d ps 1", duty_out, period_start, d1);
        end
        cur_duty = d1;
        // Load in the period_start cycle: must wait a whole period.
        do d2 = DW'($urandom_range(1, (1 << DW) - 1)); while (d2 == cur_duty);
        duty_cmd = d2; duty_load = 1'b1;
        tick();
        duty_load = 1'b0;
        $display("duty: load %0d at counter 0", d2);
        for (int c = 1; c < PERIOD; c++) begin
            if (c != 1) tick();
            n_cmp++;
            if (duty_out !== cur_duty || period_start !== 1'b0) begin
                n_bad++; $display("FAIL duty_wait_period counter %0d got %0d ps %b want %0d ps 0", c, duty_out, period_start, cur_duty);
            end
        end
        tick();
        n_cmp++;
        if (duty_out !== d2 || period_start !== 1'b1) begin
            n_bad++; $display("FAIL duty_apply_late got %0d ps %b want %0d ps 1", duty_out, period_start, d2);
        end
        cur_duty = d2;
    endtask

    task automatic test_rotation();
        logic [2:0] q_code [$];
        logic       q_dir [$];
        logic [2:0] tc;
        logic       td;
        int         lat;
        for (int i = 1; i <= 6; i++) begin q_code.push_back(FWD_SEQ[i % 6]); q_dir.push_back(1'b0); end
        q_code.push_back(3'b001); q_dir.push_back(1'b1);
        for (int i = 5; i >= 0; i--) begin q_code.push_back(FWD_SEQ[i]); q_dir.push_back(1'b1); end
        tc = 3'b001; td = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) td = ~td; else tc = other_code(tc, tc);
            q_code.push_back(tc); q_dir.push_back(td);
        end
        foreach (q_code[s]) begin
            lat = (q_code[s] != cur_code) ? ACCEPT_LAT + 1 : 1;
            hall = q_code[s]; direction = q_dir[s];
            $display("step %0d: code %b dir %b -> %b dir %b", s, cur_code, cur_dir, q_code[s], q_dir[s]);
            for (int k = 1; k < lat; k++) begin
                tick();
                n_cmp++;
                if ({high_en, low_en} !== model_pair(cur_code, cur_dir) || duty_out !== cur_duty) begin
                    n_bad++; $display("FAIL rot_old step %0d cycle %0d got %b/%b duty %0d want %b duty %0d",
                                      s, k, high_en, low_en, duty_out, model_pair(cur_code, cur_dir), cur_duty);
                end
            end
            for (int k = 0; k < GAP; k++) begin
                tick();
                n_cmp++;
                if ({high_en, low_en} !== 6'b0 || duty_out !== '0) begin
                    n_bad++; $display("FAIL rot_gap step %0d gap %0d got %b/%b duty %0d want off duty 0",
                                      s, k, high_en, low_en, duty_out);
                end
            end
            cur_code = q_code[s]; cur_dir = q_dir[s];
            for (int k = 0; k <= int'($urandom_range(0, 10)); k++) begin
                tick();
                n_cmp++;
                if ({high_en, low_en} !== model_pair(cur_code, cur_dir) || duty_out !== cur_duty) begin
                    n_bad++; $display("FAIL rot_new step %0d got %b/%b duty %0d want %b duty %0d",
                                      s, high_en, low_en, duty_out, model_pair(cur_code, cur_dir), cur_duty);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [2:0] g, n1, n2;
        int         len;
        for (int rep = 0; rep < 2; rep++) begin
            g = (rep == 0) ? other_code(cur_code, cur_code) : 3'b111;
            len = $urandom_range(1, 12);
            $display("glitch: %b for %0d cycles", g, len);
            hall = g;
            for (int k = 0; k < len + 40; k++) begin
                if (k == len) hall = cur_code;
                tick();
                n_cmp++;
                if ({high_en, low_en} !== model_pair(cur_code, cur_dir) || fault !== 1'b0) begin
                    n_bad++; $display("FAIL glitch_hold cycle %0d got %b/%b fault %b want %b fault 0",
                                      k, high_en, low_en, fault, model_pair(cur_code, cur_dir));
                end
            end
        end
        // A candidate change restarts the count: n1 for 10 cycles, then n2.
        n1 = other_code(cur_code, cur_code);
        n2 = other_code(cur_code, n1);
        $display("restart: %b for 10 cycles then %b", n1, n2);
        hall = n1;
        repeat (10) tick();
        hall = n2;
        for (int k = 1; k <= ACCEPT_LAT; k++) begin
            tick();
            n_cmp++;
            if ({high_en, low_en} !== model_pair(cur_code, cur_dir)) begin
                n_bad++; $display("FAIL restart_hold cycle %0d got %b/%b want %b", k, high_en, low_en, model_pair(cur_code, cur_dir));
            end
        end
        for (int k = 0; k < GAP; k++) begin
            tick();
            n_cmp++;
            if ({high_en, low_en} !== 6'b0) begin n_bad++; $display("FAIL restart_gap %0d got %b/%b want off", k, high_en, low_en); end
        end
        tick();
        cur_code = n2;
        n_cmp++;
        if ({high_en, low_en} !== model_pair(cur_code, cur_dir)) begin
            n_bad++; $display("FAIL restart_new got %b/%b want %b", high_en, low_en, model_pair(cur_code, cur_dir));
        end
    endtask

    task automatic test_switch_update();
        logic [2:0] n;
        n = other_code(cur_code, cur_code);
        $display("switch_update: code %b, direction flip mid-filter", n);
        hall = n;
        repeat (12) tick();
        n_cmp++;
        if ({high_en, low_en} !== model_pair(cur_code, cur_dir)) begin
            n_bad++; $display("FAIL swupd_pre got %b/%b want %b", high_en, low_en, model_pair(cur_code, cur_dir));
        end
        direction = ~cur_dir;
        for (int k = 0; k < GAP; k++) begin
            tick();
            n_cmp++;
            if ({high_en, low_en} !== 6'b0) begin n_bad++; $display("FAIL swupd_gap %0d got %b/%b want off", k, high_en, low_en); end
        end
        tick();
        cur_code = n; cur_dir = ~cur_dir;
        n_cmp++;
        if ({high_en, low_en} !== model_pair(cur_code, cur_dir)) begin
            n_bad++; $display("FAIL swupd_new got %b/%b want %b", high_en, low_en, model_pair(cur_code, cur_dir));
        end
    endtask

    task automatic test_enable();
        $display("enable: drop and restore");
        enable = 1'b0;
        tick();
        n_cmp++;
        if ({high_en, low_en} !== 6'b0 || duty_out !== '0 || fault !== 1'b0) begin
            n_bad++; $display("FAIL enable_off got %b/%b duty %0d fault %b want off", high_en, low_en, duty_out, fault);
        end
        repeat (3) tick();
        enable = 1'b1;
        tick();
        n_cmp++;
        if ({high_en, low_en} !== model_pair(cur_code, cur_dir) || duty_out !== cur_duty) begin
            n_bad++; $display("FAIL enable_on got %b/%b duty %0d want %b duty %0d",
                              high_en, low_en, duty_out, model_pair(cur_code, cur_dir), cur_duty);
        end
    endtask

    task automatic test_fault();
        $display("fault: hall=111 held");
        hall = 3'b111;
        for (int k = 1; k <= ACCEPT_LAT; k++) begin
            tick();
            n_cmp++;
            if (fault !== 1'b0 || {high_en, low_en} !== model_pair(cur_code, cur_dir)) begin
                n_bad++; $display("FAIL fault_early cycle %0d fault %b got %b/%b", k, fault, high_en, low_en);
            end
        end
        tick();
        n_cmp++;
        if (fault !== 1'b1 || {high_en, low_en} !== 6'b0 || duty_out !== '0) begin
            n_bad++; $display("FAIL fault_enter fault %b got %b/%b duty %0d want 1 off 0", fault, high_en, low_en, duty_out);
        end
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (fault !== 1'b1) begin n_bad++; $display("FAIL fault_clear_ignored got %b want 1", fault); end
        hall = 3'b001;
        for (int k = 1; k <= ACCEPT_LAT; k++) begin
            tick();
            n_cmp++;
            if (fault !== 1'b1 || {high_en, low_en} !== 6'b0) begin
                n_bad++; $display("FAIL fault_hold cycle %0d fault %b got %b/%b", k, fault, high_en, low_en);
            end
        end
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        n_cmp++;
        if (fault !== 1'b0 || {high_en, low_en} !== 6'b0) begin
            n_bad++; $display("FAIL fault_exit fault %b got %b/%b want 0 off", fault, high_en, low_en);
        end
        tick();
        cur_code = 3'b001;
        n_cmp++;
        if ({high_en, low_en} !== model_pair(cur_code, cur_dir) || duty_out !== cur_duty || fault !== 1'b0) begin
            n_bad++; $display("FAIL fault_rerun got %b/%b duty %0d want %b duty %0d",
                              high_en, low_en, duty_out, model_pair(cur_code, cur_dir), cur_duty);
        end
    endtask

    task automatic test_reset_in_switch();
        $display("reset during switch gap");
        direction = ~cur_dir;
        cur_dir = ~cur_dir;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({high_en, low_en} !== 6'b0 || fault !== 1'b0 || duty_out !== '0 || period_start !== 1'b0) begin
            n_bad++; $display("FAIL rst_async got %b/%b fault %b duty %0d ps %b want all 0",
                              high_en, low_en, fault, duty_out, period_start);
        end
        @(negedge clock);
        reset_n = 1'b1;
        cur_duty = '0;
        for (int k = 1; k <= PERIOD; k++) begin
            tick();
            n_cmp++;
            if (period_start !== (k == PERIOD)) begin
                n_bad++; $display("FAIL rst_counter cycle %0d ps %b want %b", k, period_start, (k == PERIOD));
            end
            if (k <= ACCEPT_LAT + 1) begin
                n_cmp++;
                if ({high_en, low_en} !== ((k == ACCEPT_LAT + 1) ? model_pair(cur_code, cur_dir) : 6'b0) || duty_out !== '0) begin
                    n_bad++; $display("FAIL rst_restart cycle %0d got %b/%b duty %0d", k, high_en, low_en, duty_out);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_duty();
        test_rotation();
        test_glitch();
        test_switch_update();
        test_enable();
        test_fault();
        test_reset_in_switch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
